// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// It drives the stall and flush controls for the pipeline buffers and the
// forwarding selects for the EX operands. It also runs the data-memory
// handshake FSM and keeps a saturating count of stalled cycles.
//
// Data-memory handshake (valid/ready):
//   dmem_req is the valid and dmem_ready is the ready. An access completes in
//   the cycle where both are high. A load or store in MEM raises dmem_req at
//   once. If dmem_ready is also high in that cycle, the access is zero-wait
//   and causes no stall. Otherwise the FSM enters WAIT and holds dmem_req high
//   until dmem_ready arrives, or until TIMEOUT WAIT cycles have passed. In the
//   last WAIT cycle the access is abandoned: the pipeline is released and
//   mem_err is set. mem_err stays set until reset.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             rf_en_E,
  input  logic             rf_en_M,
  input  logic             rf_en_W,
  input  logic             rd_en_E,
  input  logic             rd_en_M,
  input  logic             wr_en_M,
  input  logic             br_taken_E,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [0:0]       dbg_state
);

  // The wait counter only needs to reach TIMEOUT-1.
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state;
  logic [WC_W-1:0] wait_cnt;

  logic mem_op_M;
  logic at_limit;
  logic req_raw;
  logic mem_stall;
  logic load_use;

  // Choose the forwarding source for one EX operand. The MEM stage wins over
  // the WB stage. Register x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       en_m,
    input logic [4:0] dst_m,
    input logic       en_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (en_m && (dst_m == rs)) begin
        sel = 2'b01;
      end else if (en_w && (dst_w == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  assign mem_op_M = rd_en_M | wr_en_M;

  // This is the last WAIT cycle, when the access is abandoned.
  assign at_limit = (state == WAIT) && (wait_cnt == WC_LAST);

  // The request is raised for a fresh memory op in IDLE and held for all of WAIT.
  assign req_raw = ((state == IDLE) && mem_op_M) || (state == WAIT);

  // The pipeline freezes while a request is outstanding, except in the abort cycle.
  assign mem_stall = req_raw && !dmem_ready && !at_limit;

  // A load in EX feeds a source register of the instruction in ID.
  assign load_use = rd_en_E && rf_en_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  assign dbg_state = state;

  // Combine the hazard causes into prioritised stall/flush controls. All
  // outputs are forced low while reset is held.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_W  = 1'b0;
    fwd_a_E  = 2'b00;
    fwd_b_E  = 2'b00;
    dmem_req = 1'b0;
    if (rst) begin
      dmem_req = req_raw;
      fwd_a_E  = fwd_sel(rs1_E, rf_en_M, rd_M, rf_en_W, rd_W);
      fwd_b_E  = fwd_sel(rs2_E, rf_en_M, rd_M, rf_en_W, rd_W);
      if (mem_stall) begin
        // Freeze everything up to MEM. The instruction in MEM must not retire
        // twice, so a bubble goes into MEM/WB instead. A branch or load-use
        // hazard stays in place and is handled after the freeze.
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (br_taken_E) begin
        // The wrong-path instructions in IF/ID and ID/EX are discarded. A
        // load-use hazard on a discarded instruction does not matter.
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        // Hold the consumer in ID for one cycle and put a bubble into EX. The
        // hazard clears when the load moves on to MEM.
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Data-memory handshake FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_op_M && !dmem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (at_limit) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Count every cycle in which the front end is held, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_F && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. It runs directed scenarios and then random
// cycles. Each cycle is checked against a reference model that tracks how
// long the current memory access has been outstanding.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic             rf_en_E, rf_en_M, rf_en_W;
  logic             rd_en_E, rd_en_M, wr_en_M;
  logic             br_taken_E, dmem_ready;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       fwd_a_E, fwd_b_E;
  logic             dmem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [0:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_busy = 0;  // cycles the current access has already been outstanding
  int m_err  = 0;
  int m_cnt  = 0;

  // Expected values for the current cycle.
  logic       e_stall_F, e_stall_D, e_stall_E, e_stall_M;
  logic       e_flush_D, e_flush_E, e_flush_W, e_req;
  logic [1:0] e_fwd_a, e_fwd_b;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .rf_en_E(rf_en_E), .rf_en_M(rf_en_M), .rf_en_W(rf_en_W),
    .rd_en_E(rd_en_E), .rd_en_M(rd_en_M), .wr_en_M(wr_en_M),
    .br_taken_E(br_taken_E), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (rf_en_M && rd_M == rs) return 2'b01;
    if (rf_en_W && rd_W == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Derive every expected output from the current inputs and the model state.
  task automatic compute_expected();
    logic lu, mstall;
    {e_stall_F, e_stall_D, e_stall_E, e_stall_M} = 4'b0;
    {e_flush_D, e_flush_E, e_flush_W, e_req} = 4'b0;
    e_fwd_a = 2'b00;
    e_fwd_b = 2'b00;
    if (rst) begin
      e_req   = (rd_en_M || wr_en_M || m_busy > 0);
      mstall  = e_req && !dmem_ready && (m_busy != TIMEOUT);
      lu      = rd_en_E && rf_en_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
      e_fwd_a = model_fwd(rs1_E);
      e_fwd_b = model_fwd(rs2_E);
      if (mstall) begin
        {e_stall_F, e_stall_D, e_stall_E, e_stall_M, e_flush_W} = 5'b11111;
      end else if (br_taken_E) begin
        {e_flush_D, e_flush_E} = 2'b11;
      end else if (lu) begin
        {e_stall_F, e_stall_D, e_flush_E} = 3'b111;
      end
    end
  endtask

  // Advance the model across one rising edge.
  task automatic update_model();
    if (!rst) begin
      m_busy = 0;
      m_err  = 0;
      m_cnt  = 0;
    end else begin
      if (e_req && !dmem_ready && m_busy == TIMEOUT) m_err = 1;
      if (e_req && !dmem_ready && m_busy < TIMEOUT) m_busy = m_busy + 1;
      else m_busy = 0;
      if (e_stall_F && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  // One clock cycle. Outputs are compared at the falling edge, the model is
  // advanced at the rising edge, and new inputs may be driven 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    compute_expected();
    check("stall_F",   32'(stall_F),   32'(e_stall_F));
    check("stall_D",   32'(stall_D),   32'(e_stall_D));
    check("stall_E",   32'(stall_E),   32'(e_stall_E));
    check("stall_M",   32'(stall_M),   32'(e_stall_M));
    check("flush_D",   32'(flush_D),   32'(e_flush_D));
    check("flush_E",   32'(flush_E),   32'(e_flush_E));
    check("flush_W",   32'(flush_W),   32'(e_flush_W));
    check("fwd_a_E",   32'(fwd_a_E),   32'(e_fwd_a));
    check("fwd_b_E",   32'(fwd_b_E),   32'(e_fwd_b));
    check("dmem_req",  32'(dmem_req),  32'(e_req));
    check("mem_err",   32'(mem_err),   32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("state",     32'(dbg_state), (m_busy > 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    rf_en_E = 1'b0; rf_en_M = 1'b0; rf_en_W = 1'b0;
    rd_en_E = 1'b0; rd_en_M = 1'b0; wr_en_M = 1'b0;
    br_taken_E = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic random_inputs();
    rst        = ($urandom_range(0, 39) != 0);
    rs1_D      = 5'($urandom_range(0, 3));
    rs2_D      = 5'($urandom_range(0, 3));
    rs1_E      = 5'($urandom_range(0, 3));
    rs2_E      = 5'($urandom_range(0, 3));
    rd_E       = 5'($urandom_range(0, 3));
    rd_M       = 5'($urandom_range(0, 3));
    rd_W       = 5'($urandom_range(0, 3));
    rf_en_E    = 1'($urandom_range(0, 1));
    rf_en_M    = 1'($urandom_range(0, 1));
    rf_en_W    = 1'($urandom_range(0, 1));
    rd_en_E    = 1'($urandom_range(0, 1));
    rd_en_M    = ($urandom_range(0, 3) == 0);
    wr_en_M    = ($urandom_range(0, 4) == 0);
    br_taken_E = ($urandom_range(0, 4) == 0);
    dmem_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int cnt_start;
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds every output low, even with a forwarding match and a memory op.
    rd_en_M = 1'b1; rf_en_M = 1'b1; rd_M = 5'd1; rs1_E = 5'd1;
    cycle();
    check("rst_fwd_gate", 32'(fwd_a_E), 32'd0);
    check("rst_req_gate", 32'(dmem_req), 32'd0);
    cycle();
    clear_inputs();
    rst = 1'b1;
    cycle();

    // Load of x5 in EX, consumer in ID.
    rd_en_E = 1'b1; rf_en_E = 1'b1; rd_E = 5'd5; rs1_D = 5'd5;
    cycle();
    check("lu_stall_F", 32'(stall_F), 32'd1);
    check("lu_flush_E", 32'(flush_E), 32'd1);
    // The load is now in MEM with a zero-wait access, and the consumer is in EX.
    clear_inputs();
    rd_en_M = 1'b1; rf_en_M = 1'b1; rd_M = 5'd5; rs1_E = 5'd5; dmem_ready = 1'b1;
    cycle();
    check("lu_fwd_a", 32'(fwd_a_E), 32'd1);
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    // MEM beats WB. Register x0 is never forwarded. WB alone gives select 10.
    clear_inputs();
    rf_en_M = 1'b1; rf_en_W = 1'b1; rd_M = 5'd3; rd_W = 5'd3; rs2_E = 5'd3;
    cycle();
    check("fwd_m_over_w", 32'(fwd_b_E), 32'd1);
    rd_M = 5'd0; rs1_E = 5'd0; rd_W = 5'd0;
    cycle();
    check("fwd_x0", 32'(fwd_a_E), 32'd0);
    rd_M = 5'd4; rd_W = 5'd3; rs2_E = 5'd3;
    cycle();
    check("fwd_w", 32'(fwd_b_E), 32'd2);

    // A taken branch overrides load-use.
    clear_inputs();
    rd_en_E = 1'b1; rf_en_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7; br_taken_E = 1'b1;
    cycle();
    check("br_stall_F", 32'(stall_F), 32'd0);
    check("br_flush_D", 32'(flush_D), 32'd1);

    // Load in MEM with three not-ready cycles, then ready. A branch and a
    // load-use hazard arrive during the freeze.
    clear_inputs();
    cnt_start = m_cnt;
    rd_en_M = 1'b1;
    cycle();
    br_taken_E = 1'b1; rd_en_E = 1'b1; rf_en_E = 1'b1; rd_E = 5'd2; rs1_D = 5'd2;
    cycle();
    cycle();
    dmem_ready = 1'b1;
    cycle();
    check("wait_cnt3", 32'(stall_cnt), 32'(cnt_start + 3));
    check("wait_idle", 32'(dbg_state), 32'd0);

    // Store that never completes: the access is abandoned on the last WAIT cycle.
    clear_inputs();
    wr_en_M = 1'b1;
    for (int i = 0; i < TIMEOUT + 1; i++) cycle();
    check("to_err", 32'(mem_err), 32'd1);
    check("to_idle", 32'(dbg_state), 32'd0);
    wr_en_M = 1'b0;
    cycle();
    cycle();
    check("to_sticky", 32'(mem_err), 32'd1);

    // Reset while waiting.
    rd_en_M = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_err", 32'(mem_err), 32'd0);
    check("rstw_cnt", 32'(stall_cnt), 32'd0);
    check("rstw_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    rd_en_M = 1'b0;
    cycle();

    // Random cycles checked against the model. These also exercise counter saturation.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline controller for the 5-stage RV32 core. Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Generates stall/flush controls for load-use hazards and taken branches, and forwarding selects for the EX operands. Runs a data-memory handshake FSM that freezes the pipeline while a variable-latency data memory access in MEM is outstanding. Also keeps a saturating stall-cycle counter.

Parameters:
TIMEOUT, 255, max WAIT cycles before a memory access is aborted (≥2)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
rs1_D, rs2_D  in  5  source regs of instruction in ID
rs1_E, rs2_E  in  5  source regs of instruction in EX
rd_E, rd_M, rd_W  in  5  dest regs in EX/MEM/WB
rf_en_E, rf_en_M, rf_en_W  in  1  regfile write enable per stage
rd_en_E  in  1  instruction in EX is a load
rd_en_M, wr_en_M  in  1  load/store in MEM
br_taken_E  in  1  branch/jump resolved taken in EX
dmem_ready  in  1  data memory completes access this cycle
stall_F, stall_D  out  1  hold PC / IF-ID buffer
stall_E, stall_M  out  1  hold ID-EX / EX-MEM buffer
flush_D, flush_E, flush_W  out  1  load bubble into IF-ID / ID-EX / MEM-WB
fwd_a_E, fwd_b_E  out  2  operand select: 00 regfile, 01 alu_out_M, 10 writeback data W
dmem_req  out  1  data memory request
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0 at clk edge): state←IDLE, wait_cnt←0, mem_err←0, stall_cnt←0. While rst=0, all stall/flush/dmem_req outputs =0 and fwd =00 (combinationally gated).
- mem_op_M = rd_en_M | wr_en_M.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when mem_op_M & ~dmem_ready.
  - WAIT → IDLE when dmem_ready, or when wait_cnt==TIMEOUT-1 (abort; mem_err←1, sticky until reset).
  - wait_cnt clears in IDLE and increments each WAIT cycle.
- dmem_req = (IDLE & mem_op_M) | WAIT. Same-cycle ready in IDLE = zero-wait access, no stall.
- mem_stall = dmem_req & ~dmem_ready & ~(WAIT & wait_cnt==TIMEOUT-1).
- load_use = rd_en_E & rf_en_E & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D).
- Priority, highest first:
  1. mem_stall: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, all other flushes 0. Branch and load-use are held, not acted on.
  2. br_taken_E: flush_D=flush_E=1, no stalls (a pending load-use is discarded).
  3. load_use: stall_F=stall_D=1, flush_E=1, for exactly one cycle per hazard.
- Forwarding (combinational, independent of stalls), per operand; fwd_b_E identical using rs2_E:
  - fwd_a_E=01 if rf_en_M & rd_M≠0 & rd_M==rs1_E;
  - else 10 if rf_en_W & rd_W≠0 & rd_W==rs1_E;
  - else 00.
  - MEM beats WB. x0 is never forwarded.
- stall_cnt increments on every cycle where stall_F=1 (any cause) and saturates at all-ones.
- Reset mid-WAIT: next cycle IDLE, dmem_req low immediately while rst=0.

Test Plan:
- Load x5 in EX (rd_en_E=1, rf_en_E=1, rd_E=5), rs1_D=5 → stall_F=stall_D=flush_E=1 for 1 cycle. Next cycle, with load in MEM and rd_M=5, rs1_E=5 → fwd_a_E=01. stall_cnt=1.
- rd_M=3, rd_W=3, both rf_en=1, rs2_E=3 → fwd_b_E=01. With rd_M=0, rf_en_M=1, rs1_E=0 → fwd_a_E=00.
- br_taken_E=1 together with load_use → flush_D=flush_E=1, stall_F=0.
- rd_en_M=1, dmem_ready low for 3 cycles then high → dmem_req high 4 cycles, all stalls + flush_W high 3 cycles, release on the ready cycle, stall_cnt=3.
- TIMEOUT=4, wr_en_M=1, dmem_ready never asserted → stall cycles IDLE,WAIT,WAIT,WAIT (4 total); on the 4th WAIT cycle no stall, mem_err=1 and stays 1; FSM returns to IDLE.
- rst=0 asserted during WAIT → next cycle dmem_req=0, mem_err=0, stall_cnt=0, state IDLE.
